// File: rtl/vga_tile_scan.sv
// 640x480 VGA raster/tile scan generator: registered, zero-skew sync, video_on, pixel/tile coordinates and line/frame strobes.
// Optional `PIXEL_DIV_EN: 50 MHz in_clk, each pixel held for two clocks.
module vga_tile_scan #(
  parameter int H_VIS      = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_VIS      = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int TILE_SHIFT = 4
) (
  input  logic       in_clk,
  input  logic       reset,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y,
  output logic [9:0] tile_x,
  output logic [9:0] tile_y,
  output logic       line_end,
  output logic       frame_end
);

  localparam logic [9:0] H_TOTAL  = 10'(H_VIS + H_FP + H_SYNC + H_BP);
  localparam logic [9:0] V_TOTAL  = 10'(V_VIS + V_FP + V_SYNC + V_BP);
  localparam logic [9:0] H_VIS_W  = 10'(H_VIS);
  localparam logic [9:0] V_VIS_W  = 10'(V_VIS);
  localparam logic [9:0] HS_START = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_VIS + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_VIS + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_VIS + V_FP + V_SYNC);

  logic       pix_en;
  logic       x_wrap;
  logic       y_wrap;
  logic [9:0] next_x;
  logic [9:0] next_y;

`ifdef PIXEL_DIV_EN
  logic pix_en_q;

  always_ff @(posedge in_clk or negedge reset) begin
    if (!reset) pix_en_q <= 1'b0;
    else        pix_en_q <= ~pix_en_q;
  end

  assign pix_en = pix_en_q;
`else
  assign pix_en = 1'b1;
`endif

  // Wrap on >= so a counter can never run past its last value.
  always_comb begin
    x_wrap = (pix_x >= H_TOTAL - 10'd1);
    y_wrap = (pix_y >= V_TOTAL - 10'd1);
    next_x = x_wrap ? 10'd0 : pix_x + 10'd1;
    next_y = pix_y;
    if (x_wrap) next_y = y_wrap ? 10'd0 : pix_y + 10'd1;
  end

  // Every output is derived from the next coordinates so all of them change together with pix_x/pix_y.
  always_ff @(posedge in_clk or negedge reset) begin
    if (!reset) begin
      pix_x     <= 10'd0;
      pix_y     <= 10'd0;
      tile_x    <= 10'd0;
      tile_y    <= 10'd0;
      hsync     <= 1'b1;
      vsync     <= 1'b1;
      video_on  <= 1'b0;
      line_end  <= 1'b0;
      frame_end <= 1'b0;
    end else begin
      line_end  <= 1'b0;
      frame_end <= 1'b0;
      if (pix_en) begin
        pix_x     <= next_x;
        pix_y     <= next_y;
        tile_x    <= next_x >> TILE_SHIFT;
        tile_y    <= next_y >> TILE_SHIFT;
        hsync     <= !((next_x >= HS_START) && (next_x < HS_END));
        vsync     <= !((next_y >= VS_START) && (next_y < VS_END));
        video_on  <= (next_x < H_VIS_W) && (next_y < V_VIS_W);
        line_end  <= x_wrap;
        frame_end <= x_wrap && y_wrap;
      end
    end
  end

endmodule

// File: tb/tb_vga_tile_scan.sv
// Testbench for vga_tile_scan: a full-size instance for line timing and a shrunken-parameter
// instance for frame timing and mid-frame reset, both checked every cycle against a closed-form model.
module tb_vga_tile_scan;

`ifdef PIXEL_DIV_EN
  localparam int DIV = 2;
`else
  localparam int DIV = 1;
`endif

  typedef struct packed {
    logic [9:0] px;
    logic [9:0] py;
    logic [9:0] tx;
    logic [9:0] ty;
    logic       hs;
    logic       vs;
    logic       von;
    logic       le;
    logic       fe;
  } outs_t;

  logic in_clk = 1'b0;
  logic reset_b, reset_s;
  logic hsync_b, vsync_b, video_on_b, line_end_b, frame_end_b;
  logic hsync_s, vsync_s, video_on_s, line_end_s, frame_end_s;
  logic [9:0] pix_x_b, pix_y_b, tile_x_b, tile_y_b;
  logic [9:0] pix_x_s, pix_y_s, tile_x_s, tile_y_s;

  int compared = 0;
  int failed = 0;
  int edges = 0;
  int t_b = 0;
  int t_s = 0;
  bit counting = 1'b0;
  int hs_low_b = 0, le_cnt_b = 0, fe_cnt_b = 0;
  int vs_low_s = 0, le_cnt_s = 0, fe_cnt_s = 0;

  always #5 in_clk = ~in_clk;

  vga_tile_scan dut_big (
    .in_clk(in_clk), .reset(reset_b), .hsync(hsync_b), .vsync(vsync_b),
    .video_on(video_on_b), .pix_x(pix_x_b), .pix_y(pix_y_b),
    .tile_x(tile_x_b), .tile_y(tile_y_b), .line_end(line_end_b), .frame_end(frame_end_b)
  );

  // 28 x 16 total raster, 20 x 10 visible, 4-pixel tiles
  vga_tile_scan #(
    .H_VIS(20), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_VIS(10), .V_FP(2), .V_SYNC(2), .V_BP(2), .TILE_SHIFT(2)
  ) dut_small (
    .in_clk(in_clk), .reset(reset_s), .hsync(hsync_s), .vsync(vsync_s),
    .video_on(video_on_s), .pix_x(pix_x_s), .pix_y(pix_y_s),
    .tile_x(tile_x_s), .tile_y(tile_y_s), .line_end(line_end_s), .frame_end(frame_end_s)
  );

  // Expected outputs after t clock edges since reset release, computed directly from the raster rules.
  function automatic outs_t model(input int t, input int hv, input int hf, input int hs, input int hb,
                                  input int vv, input int vf, input int vs, input int vb, input int ts);
    outs_t o;
    int ht, vt, p, x, y;
    bit adv;
    ht  = hv + hf + hs + hb;
    vt  = vv + vf + vs + vb;
    p   = t / DIV;
    adv = (t > 0) && (t % DIV == 0);
    x   = p % ht;
    y   = (p / ht) % vt;
    o.px  = 10'(x);
    o.py  = 10'(y);
    o.tx  = 10'(x >> ts);
    o.ty  = 10'(y >> ts);
    o.hs  = !((x >= hv + hf) && (x < hv + hf + hs));
    o.vs  = !((y >= vv + vf) && (y < vv + vf + vs));
    o.von = (p > 0) && (x < hv) && (y < vv);
    o.le  = adv && (x == 0);
    o.fe  = adv && (x == 0) && (y == 0);
    return o;
  endfunction

  always @(posedge in_clk or negedge reset_b) begin
    if (!reset_b) t_b <= 0;
    else          t_b <= t_b + 1;
  end

  always @(posedge in_clk or negedge reset_s) begin
    if (!reset_s) t_s <= 0;
    else          t_s <= t_s + 1;
  end

  // Per-cycle comparison of both instances against the model, plus pulse/low-time tallies.
  always @(negedge in_clk) begin
    outs_t got_b, exp_b, got_s, exp_s;
    got_b = {pix_x_b, pix_y_b, tile_x_b, tile_y_b, hsync_b, vsync_b, video_on_b, line_end_b, frame_end_b};
    got_s = {pix_x_s, pix_y_s, tile_x_s, tile_y_s, hsync_s, vsync_s, video_on_s, line_end_s, frame_end_s};
    exp_b = model(t_b, 640, 16, 96, 48, 480, 10, 2, 33, 4);
    exp_s = model(t_s, 20, 2, 3, 3, 10, 2, 2, 2, 2);
    compared += 2;
    if (got_b !== exp_b) begin
      failed++;
      $display("[TB] FAIL cycle_big t=%0d got x=%0d y=%0d tx=%0d ty=%0d hs=%b vs=%b von=%b le=%b fe=%b want x=%0d y=%0d tx=%0d ty=%0d hs=%b vs=%b von=%b le=%b fe=%b",
               t_b, got_b.px, got_b.py, got_b.tx, got_b.ty, got_b.hs, got_b.vs, got_b.von, got_b.le, got_b.fe,
               exp_b.px, exp_b.py, exp_b.tx, exp_b.ty, exp_b.hs, exp_b.vs, exp_b.von, exp_b.le, exp_b.fe);
    end
    if (got_s !== exp_s) begin
      failed++;
      $display("[TB] FAIL cycle_small t=%0d got x=%0d y=%0d tx=%0d ty=%0d hs=%b vs=%b von=%b le=%b fe=%b want x=%0d y=%0d tx=%0d ty=%0d hs=%b vs=%b von=%b le=%b fe=%b",
               t_s, got_s.px, got_s.py, got_s.tx, got_s.ty, got_s.hs, got_s.vs, got_s.von, got_s.le, got_s.fe,
               exp_s.px, exp_s.py, exp_s.tx, exp_s.ty, exp_s.hs, exp_s.vs, exp_s.von, exp_s.le, exp_s.fe);
    end
    if (counting) begin
      if (!hsync_b)   hs_low_b++;
      if (line_end_b) le_cnt_b++;
      if (frame_end_b) fe_cnt_b++;
      if (!vsync_s)   vs_low_s++;
      if (line_end_s) le_cnt_s++;
      if (frame_end_s) fe_cnt_s++;
    end
  end

  task automatic checkOutput(input string name, input int got, input int want);
    compared++;
    if (got != want) begin
      failed++;
      $display("[TB] FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  task automatic applyStimulus(input logic rb, input logic rs);
    @(negedge in_clk);
    reset_b = rb;
    reset_s = rs;
  endtask

  // Advance to the cycle showing pixel index p since release, sampling 1 ns after the edge.
  task automatic gotoPixel(input int p);
    repeat (DIV * p - edges) @(posedge in_clk);
    edges = DIV * p;
    #1;
  endtask

  initial begin
    reset_b = 1'b0;
    reset_s = 1'b0;
    repeat (3) @(posedge in_clk);
    #1;
    checkOutput("rst_pix_x", pix_x_b, 0);
    checkOutput("rst_hsync", hsync_b, 1);
    checkOutput("rst_vsync", vsync_b, 1);
    checkOutput("rst_video_on", video_on_b, 0);
    checkOutput("rst_line_end", line_end_s, 0);

    applyStimulus(1'b1, 1'b1);
    edges = 0;
    counting = 1'b1;

    gotoPixel(1);
    checkOutput("first_pix_x", pix_x_b, 1);
    checkOutput("first_pix_y", pix_y_b, 0);
    checkOutput("first_video_on", video_on_b, 1);
    checkOutput("first_line_end", line_end_b, 0);
    gotoPixel(271);
    checkOutput("small_last_vis_tile_x", tile_x_s, 4);
    checkOutput("small_last_vis_tile_y", tile_y_s, 2);
    checkOutput("small_last_vis_video_on", video_on_s, 1);
    gotoPixel(272);
    checkOutput("small_blank_tile_x", tile_x_s, 5);
    checkOutput("small_blank_video_on", video_on_s, 0);
    gotoPixel(336);
    checkOutput("small_vsync_low", vsync_s, 0);
    gotoPixel(447);
    checkOutput("small_end_pix_x", pix_x_s, 27);
    checkOutput("small_end_tile_y", tile_y_s, 3);
    gotoPixel(448);
    checkOutput("small_wrap_pix_y", pix_y_s, 0);
    checkOutput("small_frame_end", frame_end_s, 1);
    gotoPixel(639);
    checkOutput("tile_x_639", tile_x_b, 39);
    checkOutput("video_on_639", video_on_b, 1);
    gotoPixel(640);
    checkOutput("tile_x_640", tile_x_b, 40);
    checkOutput("video_on_640", video_on_b, 0);
    gotoPixel(656);
    checkOutput("hsync_656", hsync_b, 0);
    gotoPixel(751);
    checkOutput("hsync_751", hsync_b, 0);
    gotoPixel(752);
    checkOutput("hsync_752", hsync_b, 1);
    gotoPixel(800);
    checkOutput("wrap_pix_x", pix_x_b, 0);
    checkOutput("wrap_pix_y", pix_y_b, 1);
    checkOutput("wrap_line_end", line_end_b, 1);
    checkOutput("wrap_frame_end", frame_end_b, 0);
    gotoPixel(1000);
    counting = 1'b0;
    checkOutput("hsync_low_cycles", hs_low_b, 96 * DIV);
    checkOutput("big_line_end_pulses", le_cnt_b, 1);
    checkOutput("big_frame_end_pulses", fe_cnt_b, 0);
    checkOutput("small_vsync_low_cycles", vs_low_s, 112 * DIV);
    checkOutput("small_line_end_pulses", le_cnt_s, 35);
    checkOutput("small_frame_end_pulses", fe_cnt_s, 2);
    checkOutput("small_pre_reset_x", pix_x_s, 20);
    checkOutput("small_pre_reset_y", pix_y_s, 3);

    // Mid-cycle reset must clear outputs without waiting for a clock edge.
    #2;
    reset_s = 1'b0;
    #1;
    checkOutput("async_rst_pix_x", pix_x_s, 0);
    checkOutput("async_rst_pix_y", pix_y_s, 0);
    checkOutput("async_rst_hsync", hsync_s, 1);
    checkOutput("async_rst_vsync", vsync_s, 1);
    checkOutput("async_rst_video_on", video_on_s, 0);
    applyStimulus(1'b1, 1'b1);
    repeat (DIV) @(posedge in_clk);
    #1;
    checkOutput("restart_pix_x", pix_x_s, 1);
    checkOutput("restart_pix_y", pix_y_s, 0);
    checkOutput("restart_video_on", video_on_s, 1);
    checkOutput("restart_line_end", line_end_s, 0);
    repeat (4) @(posedge in_clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
